// File: rtl/cdc_xfer_ctrl.sv
// cdc_xfer_ctrl: source-domain side of a four-phase req/ack word transfer.
// Holds each accepted word on xfer_data while xfer_req is high, synchronizes
// the far-side acknowledge, and counts completed transfers.
// Optional feature macro: CDC_XFER_CTRL_TIMEOUT_EN adds a REQ-phase timeout
// counter, the timeout pulse and the err_count saturating counter.

module cdc_xfer_ctrl #(
    parameter int unsigned N           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         req_valid,
    input  logic [N-1:0] req_data,
    output logic         req_ready,
    input  logic         ack_async,
    output logic         xfer_req,
    output logic [N-1:0] xfer_data,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [7:0]   xfer_count,
    output logic [7:0]   err_count
);

    // Reject illegal configurations at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("cdc_xfer_ctrl: SYNC_STAGES must be in 2..4");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("cdc_xfer_ctrl: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRelease
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_sync;
    logic                   xfer_req_q, xfer_req_d;
    logic [N-1:0]           xfer_data_q, xfer_data_d;
    logic                   done_q, done_d;
    logic [7:0]             xfer_count_q, xfer_count_d;

`ifdef CDC_XFER_CTRL_TIMEOUT_EN
    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       tmo_pulse_q, tmo_pulse_d;
    logic [7:0] err_count_q, err_count_d;
    logic       tmo_hit;

    // Terminal count compares the pre-increment value, so the abort lands
    // TIMEOUT+1 edges after the accept.
    assign tmo_hit = (tmo_cnt_q == TimeoutVal);
`endif

    assign ack_sync  = sync_q[SYNC_STAGES-1];
    // Stale ack blocks acceptance so xfer_req never rises while ack_sync is high.
    assign req_ready = (state_q == StIdle) && ena && !ack_sync;
    assign busy      = (state_q != StIdle);

    // Acknowledge synchronizer chain; only the last stage is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_async};
        end
    end

    // Next-state and registered-output logic for the handshake FSM.
    always_comb begin
        state_d      = state_q;
        xfer_req_d   = xfer_req_q;
        xfer_data_d  = xfer_data_q;
        done_d       = 1'b0;
        xfer_count_d = xfer_count_q;
`ifdef CDC_XFER_CTRL_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        tmo_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    xfer_data_d = req_data;
                    xfer_req_d  = 1'b1;
`ifdef CDC_XFER_CTRL_TIMEOUT_EN
                    tmo_cnt_d   = 8'd0;
`endif
                    state_d     = StReq;
                end
            end
            StReq: begin
`ifdef CDC_XFER_CTRL_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
                // Ack takes priority over a coincident terminal count.
                if (ack_sync) begin
                    xfer_req_d   = 1'b0;
                    done_d       = 1'b1;
                    xfer_count_d = (xfer_count_q == 8'hFF) ? xfer_count_q
                                                           : xfer_count_q + 8'd1;
                    state_d      = StRelease;
                end
`ifdef CDC_XFER_CTRL_TIMEOUT_EN
                else if (tmo_hit) begin
                    xfer_req_d  = 1'b0;
                    tmo_pulse_d = 1'b1;
                    err_count_d = (err_count_q == 8'hFF) ? err_count_q
                                                         : err_count_q + 8'd1;
                    state_d     = StRelease;
                end
`endif
            end
            StRelease: begin
                xfer_req_d = 1'b0;
                if (!ack_sync) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d    = StIdle;
                xfer_req_d = 1'b0;
            end
        endcase
    end

    // Handshake state, outputs and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            xfer_req_q   <= 1'b0;
            xfer_data_q  <= '0;
            done_q       <= 1'b0;
            xfer_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            xfer_req_q   <= xfer_req_d;
            xfer_data_q  <= xfer_data_d;
            done_q       <= done_d;
            xfer_count_q <= xfer_count_d;
        end
    end

`ifdef CDC_XFER_CTRL_TIMEOUT_EN
    // Timeout counter, abort pulse and abort counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q   <= 8'd0;
            tmo_pulse_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_pulse_q <= tmo_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign timeout   = tmo_pulse_q;
    assign err_count = err_count_q;
`else
    assign timeout   = 1'b0;
    assign err_count = 8'h00;
`endif

    assign xfer_req   = xfer_req_q;
    assign xfer_data  = xfer_data_q;
    assign done       = done_q;
    assign xfer_count = xfer_count_q;

endmodule
